// File: rtl/icache_pkg.sv
// Shared package common: cache FSM states, MMIO region bit, bus structs and cbus burst/size encodings.
package common;

  localparam int MMIO_BIT = 31;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] MSIZE8      = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    UNCACHED,
    RESP
  } icache_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  function automatic logic [31:0] half_sel(input logic [63:0] word, input logic hi);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/icache_if.sv
// Instruction-fetch bus (core -> cache) and cached bus (cache -> arbiter) interfaces.
interface ibus_if;
  import common::*;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  modport master(output ireq, input iresp);
  modport slave(input ireq, output iresp);
endinterface

interface cbus_if;
  import common::*;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  modport master(output creq, input cresp);
  modport slave(input creq, output cresp);
endinterface

// File: rtl/icache_data_ram.sv
// Line data storage: one write port, one combinational read port (maps to distributed RAM).
module icache_data_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);
  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache, burst line refill, MMIO single-beat bypass.
// Define ICACHE_FENCEI_EN to add the fence_i invalidate-all port.
module icache
  import common::*;
#(
  parameter int LINES = 64,
  parameter int WORDS = 8
) (
  input  logic   clk,
  input  logic   rst,
  ibus_if.slave  ibus,
  cbus_if.master cbus
`ifdef ICACHE_FENCEI_EN
  ,
  input  logic   fence_i
`endif
);
  localparam int WB   = $clog2(WORDS);
  localparam int OFS  = WB + 3;
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 64 - OFS - IDX;
  localparam int RAW  = IDX + WB;

  icache_state_t    state_reg, state_next;
  cbus_req_t        creq_reg;
  ibus_resp_t       resp;
  logic [63:0]      addr_reg;
  logic [WB-1:0]    word_cnt_reg;
  logic [63:0]      uc_data_reg;
  logic             uc_reg;
  logic             fence_pend_reg;
  logic [LINES-1:0] valid_reg, valid_next;
  logic [TAGW-1:0]  tag_mem [LINES];

  logic             fence_now, fence_clear;
  logic             fill_start, uc_start, beat_we, fill_done, uc_done;
  logic [IDX-1:0]   req_idx, fill_idx;
  logic [TAGW-1:0]  req_tag;
  logic             req_mmio, hit;
  logic [RAW-1:0]   ram_raddr, ram_waddr;
  logic [63:0]      ram_rdata;
  logic             unused_bits;

`ifdef ICACHE_FENCEI_EN
  assign fence_now = fence_i;
`else
  assign fence_now = 1'b0;
`endif

  assign req_idx  = ibus.ireq.addr[OFS+IDX-1:OFS];
  assign req_tag  = ibus.ireq.addr[63:OFS+IDX];
  assign req_mmio = ~ibus.ireq.addr[MMIO_BIT];
  assign fill_idx = addr_reg[OFS+IDX-1:OFS];

  // A fence in IDLE suppresses hits this cycle since the clear lands at the next edge.
  assign hit = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag) && !fence_now;

  assign fence_clear = (fence_now && state_reg == IDLE) ||
                       (state_reg == RESP && (fence_pend_reg || fence_now));

  // IDLE looks up the live request; FILL/RESP use the latched line.
  assign ram_raddr = (state_reg == IDLE) ? ibus.ireq.addr[OFS+IDX-1:3] : addr_reg[OFS+IDX-1:3];
  assign ram_waddr = {fill_idx, word_cnt_reg};

  icache_data_ram #(
    .DEPTH(LINES * WORDS),
    .AW   (RAW)
  ) u_data (
    .clk  (clk),
    .we   (beat_we),
    .waddr(ram_waddr),
    .wdata(cbus.cresp.data),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    resp       = '0;
    fill_start = 1'b0;
    uc_start   = 1'b0;
    beat_we    = 1'b0;
    fill_done  = 1'b0;
    uc_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ibus.ireq.valid) begin
          if (req_mmio) begin
            uc_start   = 1'b1;
            state_next = UNCACHED;
          end else if (hit) begin
            resp.addr_ok = 1'b1;
            resp.data_ok = 1'b1;
            resp.data    = half_sel(ram_rdata, ibus.ireq.addr[2]);
          end else begin
            fill_start = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (cbus.cresp.ready) begin
          beat_we = 1'b1;
          if (cbus.cresp.last) begin
            fill_done  = 1'b1;
            state_next = RESP;
          end
        end
      end
      UNCACHED: begin
        if (cbus.cresp.ready && cbus.cresp.last) begin
          uc_done    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp.addr_ok = 1'b1;
        resp.data_ok = 1'b1;
        resp.data    = half_sel(uc_reg ? uc_data_reg : ram_rdata, addr_reg[2]);
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ibus.iresp = resp;
  assign cbus.creq  = creq_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      creq_reg       <= '0;
      addr_reg       <= '0;
      word_cnt_reg   <= '0;
      uc_data_reg    <= '0;
      uc_reg         <= 1'b0;
      fence_pend_reg <= 1'b0;
    end else begin
      if (fill_start) begin
        addr_reg       <= ibus.ireq.addr;
        uc_reg         <= 1'b0;
        word_cnt_reg   <= '0;
        creq_reg.valid    <= 1'b1;
        creq_reg.is_write <= 1'b0;
        creq_reg.size     <= MSIZE8;
        creq_reg.addr     <= {ibus.ireq.addr[63:OFS], {OFS{1'b0}}};
        creq_reg.len      <= 8'(WORDS - 1);
        creq_reg.burst    <= BURST_INCR;
      end else if (uc_start) begin
        addr_reg       <= ibus.ireq.addr;
        uc_reg         <= 1'b1;
        creq_reg.valid    <= 1'b1;
        creq_reg.is_write <= 1'b0;
        creq_reg.size     <= MSIZE8;
        creq_reg.addr     <= {ibus.ireq.addr[63:3], 3'b000};
        creq_reg.len      <= 8'd0;
        creq_reg.burst    <= BURST_FIXED;
      end
      if (beat_we) word_cnt_reg <= fill_done ? '0 : word_cnt_reg + WB'(1);
      if (uc_done) uc_data_reg <= cbus.cresp.data;
      if (fill_done || uc_done) creq_reg.valid <= 1'b0;
      // Fences seen mid-transaction are replayed as the FSM returns to IDLE.
      if (state_reg == RESP)                  fence_pend_reg <= 1'b0;
      else if (fence_now && state_reg != IDLE) fence_pend_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    assign valid_next[gi] = fence_clear ? 1'b0 :
                            (fill_done && fill_idx == IDX'(gi)) ? 1'b1 : valid_reg[gi];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_reg <= '0;
    else      valid_reg <= valid_next;
  end

  always_ff @(posedge clk) begin
    if (fill_done) tag_mem[fill_idx] <= addr_reg[63:OFS+IDX];
  end

  assign unused_bits = ^{ibus.ireq.addr[1:0], addr_reg[1:0]};

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed cases then random fetches against a line-map model.
module tb_icache;
  import common::*;

  localparam int LINES = 64;
  localparam int WORDS = 8;

  logic clk;
  logic rst;
`ifdef ICACHE_FENCEI_EN
  logic fence_i;
`endif

  ibus_if ibus ();
  cbus_if cbus ();

  icache #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ibus(ibus),
    .cbus(cbus)
`ifdef ICACHE_FENCEI_EN
    ,
    .fence_i(fence_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: line index -> resident line base address
  logic [63:0] m_line [int];

  int          f_cycles, f_beats, f_bursts, f_fence_cyc;
  logic [63:0] f_baddr, f_bus_word;
  logic [7:0]  f_blen;
  logic [2:0]  f_bsize;
  logic [31:0] f_data;
  bit          f_done;
  int          mmio_serial = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_0000, {a[15:0], a[31:16]} + 32'h1357};
  endfunction

  function automatic logic [31:0] half_of(input logic [63:0] w, input logic hi);
    return hi ? w[63:32] : w[31:0];
  endfunction

  task automatic fetch(input logic [63:0] a, input int gap, input int fence_at);
    int beat;
    beat = 0;
    f_done = 0; f_cycles = 0; f_beats = 0; f_bursts = 0; f_fence_cyc = -1;
    f_data = '0; f_bus_word = '0; f_baddr = '0; f_blen = '0; f_bsize = '0;
    @(negedge clk);
    ibus.ireq.valid = 1'b1;
    ibus.ireq.addr  = a;
    for (int c = 0; c < 200 && !f_done; c++) begin
      cbus.cresp = '0;
      if (cbus.creq.valid && $urandom_range(99) >= gap) begin
        logic [63:0] ba;
        ba = cbus.creq.addr + 64'(beat * 8);
        cbus.cresp.ready = 1'b1;
        cbus.cresp.last  = (beat == int'(cbus.creq.len));
        if (ba[31]) cbus.cresp.data = mem_word(ba);
        else begin
          mmio_serial++;
          cbus.cresp.data = mem_word(ba) ^ {32'(mmio_serial), 32'(mmio_serial * 7)};
          f_bus_word = cbus.cresp.data;
        end
        if (beat == 0) begin
          f_bursts++;
          f_baddr = cbus.creq.addr;
          f_blen  = cbus.creq.len;
          f_bsize = cbus.creq.size;
        end
        f_beats++;
        beat = cbus.cresp.last ? 0 : beat + 1;
      end
`ifdef ICACHE_FENCEI_EN
      fence_i = (c == fence_at);
      if (c == fence_at) f_fence_cyc = c;
`endif
      #1;
      if (ibus.iresp.data_ok) begin
        f_done   = 1;
        f_data   = ibus.iresp.data;
        f_cycles = c + 1;
      end
      @(negedge clk);
    end
    ibus.ireq.valid = 1'b0;
    cbus.cresp = '0;
`ifdef ICACHE_FENCEI_EN
    fence_i = 1'b0;
`endif
    chk("no_timeout", 64'(f_done), 64'd1);
  endtask

  task automatic run_fetch(input string tag, input logic [63:0] a, input int gap, input int fence_at);
    logic [63:0] line;
    logic [31:0] exp_data;
    int idx;
    bit mmio, hit;
    line = a & ~64'(WORDS * 8 - 1);
    idx  = int'((a >> 6) % LINES);
    mmio = !a[31];
    fetch(a, gap, fence_at);
    if (f_fence_cyc == 0) m_line.delete();
    hit = !mmio && m_line.exists(idx) && (m_line[idx] == line);
    exp_data = mmio ? half_of(f_bus_word, a[2]) : half_of(mem_word(a & ~64'h7), a[2]);
    chk({tag, "_data"}, 64'(f_data), 64'(exp_data));
    chk({tag, "_bursts"}, 64'(f_bursts), hit ? 64'd0 : 64'd1);
    if (!hit) begin
      chk({tag, "_baddr"}, f_baddr, mmio ? (a & ~64'h7) : line);
      chk({tag, "_blen"}, 64'(f_blen), mmio ? 64'd0 : 64'(WORDS - 1));
      chk({tag, "_beats"}, 64'(f_beats), mmio ? 64'd1 : 64'(WORDS));
      chk({tag, "_bsize"}, 64'(f_bsize), 64'd3);
    end
    if (!mmio && !hit) m_line[idx] = line;
    if (f_fence_cyc > 0) m_line.delete();
    $display("fetch %-10s addr=%h data=%h cycles=%0d bursts=%0d beats=%0d %s fence=%0d",
             tag, a, f_data, f_cycles, f_bursts, f_beats, hit ? "hit " : "miss", f_fence_cyc);
  endtask

  initial begin
    logic [63:0] a;
    int gap, fat, beats;

    rst  = 1'b0;
    ibus.ireq = '0;
    cbus.cresp = '0;
`ifdef ICACHE_FENCEI_EN
    fence_i = 1'b0;
`endif
    #1;
    chk("rst_creq_valid", 64'(cbus.creq.valid), 64'd0);
    chk("rst_iresp", 64'(ibus.iresp), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_fetch("cold", 64'h8000_0000, 0, -1);
    chk("cold_cycles", 64'(f_cycles), 64'd10);
    run_fetch("hit_hi", 64'h8000_0004, 0, -1);
    chk("hit_cycles", 64'(f_cycles), 64'd1);
    run_fetch("conflict1", 64'h8000_1000, 0, -1);
    run_fetch("conflict2", 64'h8000_0000, 0, -1);
    run_fetch("conflict3", 64'h8000_1000, 0, -1);
    run_fetch("mmio1", 64'h1000_0004, 0, -1);
    chk("mmio_cycles", 64'(f_cycles), 64'd3);
    run_fetch("mmio2", 64'h1000_0004, 0, -1);

`ifdef ICACHE_FENCEI_EN
    run_fetch("fence_fill", 64'h8000_0040, 0, 3);
    run_fetch("after_fnc", 64'h8000_0040, 0, -1);
    chk("after_fnc_miss", 64'(f_bursts), 64'd1);
`endif

    for (int n = 0; n < 60; n++) begin
      a = 64'h8000_0000 | (64'($urandom_range(3)) << 12) | (64'($urandom_range(3)) << 6) |
          (64'($urandom_range(7)) << 3) | (64'($urandom_range(1)) << 2);
      if ($urandom_range(99) < 15) a[31] = 1'b0;
      if ($urandom_range(9) == 0) a[40] = 1'b1;
      gap = ($urandom_range(1) == 0) ? 0 : 40;
      fat = -1;
`ifdef ICACHE_FENCEI_EN
      if ($urandom_range(99) < 15) fat = $urandom_range(4);
`endif
      run_fetch("rand", a, gap, fat);
    end

    // reset in the middle of a refill
    a = 64'h8000_0300;
    beats = 0;
    @(negedge clk);
    ibus.ireq.valid = 1'b1;
    ibus.ireq.addr  = a;
    for (int c = 0; c < 50 && beats < 3; c++) begin
      cbus.cresp = '0;
      if (cbus.creq.valid) begin
        cbus.cresp.ready = 1'b1;
        cbus.cresp.data  = mem_word(cbus.creq.addr + 64'(beats * 8));
        beats++;
      end
      #1;
      @(negedge clk);
    end
    cbus.cresp = '0;
    chk("rst_mid_pre_valid", 64'(cbus.creq.valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_creq_valid", 64'(cbus.creq.valid), 64'd0);
    chk("rst_mid_iresp", 64'(ibus.iresp), 64'd0);
    ibus.ireq.valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_line.delete();
    $display("reset mid-refill addr=%h after %0d beats", a, beats);
    run_fetch("rst_refill", a, 0, -1);
    chk("rst_refill_cycles", 64'(f_cycles), 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the core's instruction-fetch port and the shared cached-bus arbiter. It serves `ibus_req_t` fetches from on-chip line storage and refills missing lines with one incrementing burst on the `cbus` interface. MMIO-region fetches bypass the storage as single-beat reads.

## Interface
Parameters:
- `LINES`, 64: number of lines; power of two.
- `WORDS`, 8: 64-bit words per line; power of two; burst length is `WORDS`.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-low reset; asserted when 0.
- `ireq` input `ibus_req_t`: fetch request (`valid`, `addr`).
- `iresp` output `ibus_resp_t`: `addr_ok`, `data_ok`, `data` (32-bit instruction).
- `creq` output `cbus_req_t`: `valid`, `is_write`=0, `size`, `addr`, `len`, `burst`.
- `cresp` input `cbus_resp_t`: `ready`, `last`, `data` (64-bit).
- `fence_i` input 1: present only with `ICACHE_FENCEI_EN`; invalidate-all request.

## Operation
Address split for `OFS=log2(WORDS)+3` and `IDX=log2(LINES)`:
- bit 2 selects the 32-bit half of the word;
- `[OFS-1:3]` is the word index;
- `[OFS+IDX-1:OFS]` is the line index;
- `[63:OFS+IDX]` is the tag.

Storage:
- Per-line valid bit and tag, held in flops.
- Data array of `LINES*WORDS` 64-bit words.

MMIO region: `addr[31]==0`. These fetches never allocate and never hit.

FSM states: `IDLE`, `FILL`, `UNCACHED`, `RESP`.
- **IDLE**, `ireq.valid`, cacheable, hit (valid and tag equal): `addr_ok=data_ok=1` combinationally the same cycle; `data` is the selected half. Stay in `IDLE`.
- **IDLE**, cacheable miss: latch `addr`, go to `FILL`.
  - Set `creq.valid=1`, `addr` = line-aligned, `size`=8 bytes, `len=WORDS-1`, `burst=INCR`.
  - Each `cresp.ready` writes the next word at the latched index, using a word counter that starts at 0.
  - On `ready&last`: set the valid bit, write the tag, drop `creq.valid`, go to `RESP`.
- **IDLE**, MMIO: latch `addr`, go to `UNCACHED`.
  - Set `creq.valid=1`, `addr` = request address with bits [2:0] cleared, `len=0`.
  - On `ready&last`: latch the data, go to `RESP`.
- **RESP**: `addr_ok=data_ok=1` with the filled or latched word's selected half, then go to `IDLE`.

Request and fence rules:
- The core holds `ireq.valid` and `addr` stable until `data_ok`; the cache does not re-check `addr` in `FILL`, `UNCACHED` or `RESP`.
- If `ireq.valid` is low in `RESP`, the response is still driven for that one cycle and then dropped.
- `fence_i` in `IDLE` clears all valid bits next edge; no hit may be reported that cycle.
- `fence_i` in `FILL`, `UNCACHED` or `RESP` is remembered, and the clear is applied on entry to `IDLE`. The just-filled line is invalidated too, but its pending `RESP` is still delivered.

## Timing
- Reset (`rst`=0, async): FSM `IDLE`, all valid bits 0, word counter 0, pending-fence 0.
- Output values in reset: `creq.valid=0`, `iresp` all 0.
- Data array is not reset.
- Hit latency: 0 cycles (combinational response).
- Miss latency: cycles until the first `ready`, plus `WORDS` beats, plus 1 (`RESP`).
- MMIO latency: cycles until `ready&last`, plus 1.
- `creq` fields are registered and stay stable while `creq.valid=1`; there is no retraction mid-burst.
- Reset asserted mid-burst aborts at once. `creq.valid` drops asynchronously and the partial line stays invalid; the arbiter tolerates this.
- `cresp.ready` while not in `FILL`/`UNCACHED` is ignored.

## Configuration
- `ICACHE_FENCEI_EN` defined: the `fence_i` port exists and the invalidate logic above is compiled in.
- Undefined: no port; valid bits are cleared only by reset.

## Structure
- Shared package `common`:
  - `icache_state_t` enum (`IDLE`, `FILL`, `UNCACHED`, `RESP`);
  - `MMIO_BIT` localparam (31);
  - burst encoding constants, reused from the existing `cbus` definitions.
- Sub-module `icache_data_ram`: one-write/one-read 64-bit array with combinational read; synthesises to LUTRAM.
- Tag/valid logic and FSM live in the top module.

## Test plan
- Cold fetch 0x8000_0000, 8-beat refill with `ready` every cycle → one burst at `addr` 0x8000_0000, `len` 7; `data_ok` in `RESP` with beat-0 low half; total 10 cycles.
- Fetch 0x8000_0004 after that refill → hit, `data_ok` the same cycle, `data` = beat-0 high half, `creq.valid` stays 0.
- Fetch 0x8000_1000 (same index, different tag), then 0x8000_0000 → two refills; the second evicts, third fetch misses again.
- MMIO fetch 0x1000_0004 → single beat `len` 0 at 0x1000_0000; returns the high half; the following identical fetch reissues the bus read.
- `fence_i` pulse during the fill of 0x8000_0040 → `RESP` delivers data; next fetch of 0x8000_0040 misses. The same bench without `ICACHE_FENCEI_EN` omits this case.
- `rst`=0 after beat 3 of a refill → `creq.valid` 0 immediately; after release, re-fetch of the same address performs a full 8-beat refill.
